// File: rtl/bht_predictor.sv
// rtl/bht_predictor.sv - bimodal/gshare branch history table with tagged BTB
module bht_predictor #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 8,
    parameter int GHR_W = 0
) (
    input  logic                                clk_in,
    input  logic                                rst_in,
    input  logic                                rdy_in,
    input  logic                                lookup_valid_in,
    input  logic [31:0]                         lookup_pc_in,
    output logic                                pred_valid_out,
    output logic                                pred_taken_out,
    output logic [31:0]                         pred_target_out,
    output logic [(GHR_W > 0 ? GHR_W : 1)-1:0]  pred_ghr_out,
    input  logic                                upd_valid_in,
    input  logic [31:0]                         upd_pc_in,
    input  logic                                upd_taken_in,
    input  logic [31:0]                         upd_target_in,
    input  logic [(GHR_W > 0 ? GHR_W : 1)-1:0]  upd_ghr_in,
    input  logic                                upd_mispredict_in
);

    localparam int GW = (GHR_W > 0) ? GHR_W : 1;
    localparam int N  = 1 << IDX_W;

    logic [1:0]       ctr        [N];
    logic             btb_valid  [N];
    logic [TAG_W-1:0] btb_tag    [N];
    logic [31:0]      btb_target [N];

    logic [GW-1:0]    ghr;

    logic [IDX_W-1:0] lk_bidx;
    logic [IDX_W-1:0] lk_cidx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] up_bidx;
    logic [IDX_W-1:0] up_cidx;
    logic [TAG_W-1:0] up_tag;
    logic             lk_taken;
    logic             lk_fire;
    logic             up_fire;

    // Upper PC bits beyond the tag and the byte offset never reach the tables.
    logic             unused_bits;
    assign unused_bits = ^{upd_pc_in[31:IDX_W+TAG_W+2], upd_pc_in[1:0],
                           upd_ghr_in, upd_mispredict_in};

    assign lk_fire = lookup_valid_in && rdy_in;
    assign up_fire = upd_valid_in && rdy_in;

    assign lk_bidx = lookup_pc_in[IDX_W+1:2];
    assign lk_tag  = lookup_pc_in[IDX_W+TAG_W+1:IDX_W+2];
    assign up_bidx = upd_pc_in[IDX_W+1:2];
    assign up_tag  = upd_pc_in[IDX_W+TAG_W+1:IDX_W+2];

    generate
        if (GHR_W == 0) begin : g_bimodal
            assign ghr     = '0;
            assign lk_cidx = lk_bidx;
            assign up_cidx = up_bidx;
        end else begin : g_gshare
            assign lk_cidx = lk_bidx ^ IDX_W'(ghr);
            assign up_cidx = up_bidx ^ IDX_W'(upd_ghr_in);

            // History: a mispredict repair wins over the speculative shift of a same-cycle lookup.
            always_ff @(posedge clk_in or posedge rst_in) begin
                if (rst_in) begin
                    ghr <= '0;
                end else if (rdy_in) begin
                    if (upd_valid_in && upd_mispredict_in) begin
                        ghr <= (upd_ghr_in << 1) | GW'(upd_taken_in);
                    end else if (lookup_valid_in) begin
                        ghr <= (ghr << 1) | GW'(lk_taken);
                    end
                end
            end
        end
    endgenerate

    // Reads see the tables as they were before any same-cycle training (no forwarding).
    assign lk_taken = ctr[lk_cidx][1] && btb_valid[lk_bidx] && (btb_tag[lk_bidx] == lk_tag);

    // Counter and BTB-valid training; counters come out of reset weakly not-taken.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < N; i++) begin
                ctr[i]       <= 2'b01;
                btb_valid[i] <= 1'b0;
            end
        end else if (up_fire) begin
            if (upd_taken_in) begin
                if (ctr[up_cidx] != 2'b11) begin
                    ctr[up_cidx] <= ctr[up_cidx] + 2'b01;
                end
                btb_valid[up_bidx] <= 1'b1;
            end else if (ctr[up_cidx] != 2'b00) begin
                ctr[up_cidx] <= ctr[up_cidx] - 2'b01;
            end
        end
    end

    // BTB payload write on taken branches; meaningless until the valid bit is set.
    always_ff @(posedge clk_in) begin
        if (up_fire && upd_taken_in) begin
            btb_tag[up_bidx]    <= up_tag;
            btb_target[up_bidx] <= upd_target_in;
        end
    end

    // Registered prediction: valid is a one-cycle pulse, data holds while stalled.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pred_valid_out  <= 1'b0;
            pred_taken_out  <= 1'b0;
            pred_target_out <= 32'h0;
            pred_ghr_out    <= '0;
        end else begin
            pred_valid_out <= lk_fire;
            if (lk_fire) begin
                pred_taken_out  <= lk_taken;
                pred_target_out <= lk_taken ? btb_target[lk_bidx] : lookup_pc_in + 32'd4;
                pred_ghr_out    <= ghr;
            end
        end
    end

endmodule

// File: tb/tb_bht_predictor.sv
// tb/tb_bht_predictor.sv - scoreboard bench for bht_predictor (bimodal and gshare instances)
module tb_bht_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        taken;
        logic [31:0] target;
        logic [3:0]  ghr;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;

    // bimodal instance
    logic        rst0 = 1'b1, rdy0 = 1'b1, lv0 = 1'b0, uv0 = 1'b0, ut0 = 1'b0, umis0 = 1'b0;
    logic [31:0] lpc0 = '0, upc0 = '0, utg0 = '0;
    logic [0:0]  ughr0 = '0;
    logic        pv0, pt0;
    logic [31:0] ptg0;
    logic [0:0]  pg0;

    // gshare instance
    logic        rst1 = 1'b1, rdy1 = 1'b1, lv1 = 1'b0, uv1 = 1'b0, ut1 = 1'b0, umis1 = 1'b0;
    logic [31:0] lpc1 = '0, upc1 = '0, utg1 = '0;
    logic [3:0]  ughr1 = '0;
    logic        pv1, pt1;
    logic [31:0] ptg1;
    logic [3:0]  pg1;

    bht_predictor #(.IDX_W(6), .TAG_W(8), .GHR_W(0)) dut0 (
        .clk_in(clk), .rst_in(rst0), .rdy_in(rdy0),
        .lookup_valid_in(lv0), .lookup_pc_in(lpc0),
        .pred_valid_out(pv0), .pred_taken_out(pt0), .pred_target_out(ptg0), .pred_ghr_out(pg0),
        .upd_valid_in(uv0), .upd_pc_in(upc0), .upd_taken_in(ut0), .upd_target_in(utg0),
        .upd_ghr_in(ughr0), .upd_mispredict_in(umis0)
    );

    bht_predictor #(.IDX_W(6), .TAG_W(8), .GHR_W(4)) dut1 (
        .clk_in(clk), .rst_in(rst1), .rdy_in(rdy1),
        .lookup_valid_in(lv1), .lookup_pc_in(lpc1),
        .pred_valid_out(pv1), .pred_taken_out(pt1), .pred_target_out(ptg1), .pred_ghr_out(pg1),
        .upd_valid_in(uv1), .upd_pc_in(upc1), .upd_taken_in(ut1), .upd_target_in(utg1),
        .upd_ghr_in(ughr1), .upd_mispredict_in(umis1)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic cmp_pred(input string nm, input logic pv, input logic pt,
                            input logic [31:0] ptg, input logic [3:0] pg, input exp_t e);
        chk({nm, "_valid"}, {31'b0, pv}, 32'd1);
        chk({nm, "_taken"}, {31'b0, pt}, {31'b0, e.taken});
        chk({nm, "_target"}, ptg, e.target);
        chk({nm, "_ghr"}, {28'b0, pg}, {28'b0, e.ghr});
    endtask

    // Monitor: pops an expectation whenever one falls due, flags any stray valid pulse.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            cmp_pred("d0_pred", pv0, pt0, ptg0, {3'b0, pg0}, e);
        end else if (pv0) begin
            checks++; failures++;
            $display("FAIL d0_unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            cmp_pred("d1_pred", pv1, pt1, ptg1, pg1, e);
        end else if (pv1) begin
            checks++; failures++;
            $display("FAIL d1_unexpected_valid actual=1 expected=0 (cycle %0d)", cyc);
        end
    end

    task automatic step0(input logic lv, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                         input logic rdy, input logic et, input logic [31:0] etg);
        exp_t e;
        @(negedge clk);
        lv0 = lv; lpc0 = lpc; uv0 = uv; upc0 = upc; ut0 = ut; utg0 = utg; rdy0 = rdy;
        if (lv && rdy) begin
            e.taken = et; e.target = etg; e.ghr = 4'h0; e.due = cyc + 1;
            q0.push_back(e);
        end
    endtask

    task automatic look0(input logic [31:0] pc, input logic et, input logic [31:0] etg);
        step0(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, et, etg);
    endtask

    task automatic upd0(input logic [31:0] pc, input logic t, input logic [31:0] tg);
        step0(1'b0, 32'h0, 1'b1, pc, t, tg, 1'b1, 1'b0, 32'h0);
    endtask

    task automatic step1(input logic lv, input logic [31:0] lpc, input logic uv,
                         input logic [31:0] upc, input logic ut, input logic [31:0] utg,
                         input logic [3:0] ughr, input logic umis,
                         input logic et, input logic [31:0] etg, input logic [3:0] eg);
        exp_t e;
        @(negedge clk);
        lv1 = lv; lpc1 = lpc; uv1 = uv; upc1 = upc; ut1 = ut; utg1 = utg;
        ughr1 = ughr; umis1 = umis; rdy1 = 1'b1;
        if (lv) begin
            e.taken = et; e.target = etg; e.ghr = eg; e.due = cyc + 1;
            q1.push_back(e);
        end
    endtask

    task automatic look1(input logic [31:0] pc, input logic et, input logic [31:0] etg,
                         input logic [3:0] eg);
        step1(1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, et, etg, eg);
    endtask

    task automatic upd1(input logic [31:0] pc, input logic t, input logic [31:0] tg,
                        input logic [3:0] gh, input logic mis);
        step1(1'b0, 32'h0, 1'b1, pc, t, tg, gh, mis, 1'b0, 32'h0, 4'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state of both instances
        repeat (2) @(negedge clk);
        chk("d0_rst_valid", {31'b0, pv0}, 32'd0);
        chk("d0_rst_taken", {31'b0, pt0}, 32'd0);
        chk("d0_rst_target", ptg0, 32'h0);
        chk("d1_rst_ghr", {28'b0, pg1}, 32'd0);
        rst0 = 1'b0;
        rst1 = 1'b0;

        // cold lookup: weakly not-taken, fall-through target
        look0(32'h100, 1'b0, 32'h104);
        step0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // one taken update makes it predict taken; two not-taken undo it
        upd0(32'h100, 1'b1, 32'h80);
        look0(32'h100, 1'b1, 32'h80);
        upd0(32'h100, 1'b0, 32'h0);
        upd0(32'h100, 1'b0, 32'h0);
        look0(32'h100, 1'b0, 32'h104);

        // saturation: 0 -> 3 (held) -> 2 after one not-taken
        for (int i = 0; i < 5; i++) upd0(32'h100, 1'b1, 32'h80);
        upd0(32'h100, 1'b0, 32'h0);
        look0(32'h100, 1'b1, 32'h80);

        // aliasing index with a different tag misses the BTB
        look0(32'h4100, 1'b0, 32'h4104);

        // fall-through wraps at the top of the address space
        look0(32'hFFFF_FFFC, 1'b0, 32'h0);

        // asynchronous reset clears live outputs immediately
        @(negedge clk);
        lv0 = 1'b0; uv0 = 1'b0;
        #2 rst0 = 1'b1;
        #1;
        chk("d0_async_rst_valid", {31'b0, pv0}, 32'd0);
        chk("d0_async_rst_taken", {31'b0, pt0}, 32'd0);
        chk("d0_async_rst_target", ptg0, 32'h0);
        @(negedge clk);
        rst0 = 1'b0;

        // same-cycle update and lookup: lookup sees the pre-update state
        step0(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h80, 1'b1, 1'b0, 32'h104);
        look0(32'h100, 1'b1, 32'h80);
        step0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // stalled: neither the lookup nor the not-taken updates take effect
        step0(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        step0(1'b1, 32'h100, 1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        look0(32'h100, 1'b1, 32'h80);
        step0(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 32'h0);

        // gshare: train indices 0, 1, 3 (pc 0x100 xor history)
        upd1(32'h100, 1'b1, 32'h200, 4'h0, 1'b0);
        upd1(32'h100, 1'b1, 32'h200, 4'h1, 1'b0);
        upd1(32'h100, 1'b1, 32'h200, 4'h3, 1'b0);
        look1(32'h100, 1'b1, 32'h200, 4'h0);
        look1(32'h100, 1'b1, 32'h200, 4'h1);
        look1(32'h100, 1'b1, 32'h200, 4'h3);
        look1(32'h100, 1'b0, 32'h104, 4'h7);
        // mispredict repair: {0001[2:0], 0} = 0010
        upd1(32'h100, 1'b0, 32'h0, 4'h1, 1'b1);
        look1(32'h100, 1'b0, 32'h104, 4'h2);
        // repair overrides the speculative shift of a same-cycle lookup
        step1(1'b1, 32'h100, 1'b1, 32'h100, 1'b1, 32'h200, 4'h3, 1'b1, 1'b0, 32'h104, 4'h4);
        look1(32'h100, 1'b0, 32'h104, 4'h7);

        // reset with a lookup in flight: outputs clear, no pulse afterwards
        @(negedge clk);
        lv1 = 1'b1; lpc1 = 32'h100; uv1 = 1'b0; umis1 = 1'b0;
        #2 rst1 = 1'b1;
        #1;
        chk("d1_async_rst_valid", {31'b0, pv1}, 32'd0);
        chk("d1_async_rst_target", ptg1, 32'h0);
        chk("d1_async_rst_ghr", {28'b0, pg1}, 32'd0);
        lv1 = 1'b0;
        @(negedge clk);
        rst1 = 1'b0;
        step1(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        look1(32'h100, 1'b0, 32'h104, 4'h0);

        // drain and confirm every expectation was consumed
        repeat (3) step1(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 4'h0);
        chk("d0_queue_drained", q0.size(), 32'd0);
        chk("d1_queue_drained", q1.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
